// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared opcodes, request encodings, FSM/phase enums and frame builder
package spi_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_STATUS = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH, S_GAP, S_RESP
    } state_t;

    typedef enum logic [1:0] {
        PH_READ, PH_WREN, PH_PP, PH_RDSR
    } phase_t;

    typedef struct packed {
        logic [7:0]  command;
        logic [23:0] address;
        logic [31:0] wdata;
    } frame_t;

    // Address only rides on READ/PP, data only on PP; everything else is zero.
    function automatic frame_t frame_of(input phase_t ph, input logic [23:0] addr,
                                        input logic [31:0] wdata);
        frame_t f;
        f = '0;
        case (ph)
            PH_READ: begin f.command = CMD_READ; f.address = addr; end
            PH_WREN: f.command = CMD_WREN;
            PH_PP:   begin f.command = CMD_PP; f.address = addr; f.wdata = wdata; end
            default: f.command = CMD_RDSR;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/spi_flash_sequencer.sv
// rtl/spi_flash_sequencer.sv - splits flash requests into SPI frames and polls WIP after writes
module spi_flash_sequencer
    import spi_pkg::*;
#(
    parameter int POLL_MAX      = 1024,
    parameter int CS_GAP        = 2,
    parameter int START_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        spi_en,
    output logic [7:0]  spi_command,
    output logic [23:0] spi_address,
    output logic [31:0] spi_wdata,
    input  logic        spi_cs,
    input  logic [31:0] spi_rdata
);

    localparam int CNT_MAX = (CS_GAP > START_TIMEOUT) ? CS_GAP : START_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(POLL_MAX + 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(START_TIMEOUT - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    state_t        r_state;
    phase_t        r_phase;
    logic [1:0]    r_op;
    logic [23:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_poll;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [31:0]   r_rsp_rdata;
    logic          r_spi_en;
    frame_t        r_frame;

    phase_t        w_first_phase;
    logic [31:0]   w_status;

    always_comb begin
        w_first_phase = PH_READ;
        case (req_op)
            OP_WRITE:  w_first_phase = PH_WREN;
            OP_STATUS: w_first_phase = PH_RDSR;
            default:   w_first_phase = PH_READ;
        endcase
    end

    // RDSR frames carry the status byte repeated, so the low byte is enough.
    assign w_status = {24'b0, spi_rdata[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_phase     <= PH_READ;
            r_op        <= OP_READ;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_poll      <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_spi_en    <= 1'b0;
            r_frame     <= '0;
        end else begin
            r_spi_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_op        <= req_op;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        if (req_op == OP_RSVD) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= S_RESP;
                        end else begin
                            r_phase  <= w_first_phase;
                            r_frame  <= frame_of(w_first_phase, req_addr, req_wdata);
                            r_spi_en <= 1'b1;
                            r_state  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!spi_cs) begin
                        r_state <= S_WAIT_HIGH;
                    end else if (r_cnt == TO_LAST) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (spi_cs) begin
                        r_cnt <= '0;
                        case (r_phase)
                            PH_READ: begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_rdata <= spi_rdata;
                                r_state     <= S_RESP;
                            end
                            PH_WREN: begin
                                r_phase <= PH_PP;
                                r_state <= S_GAP;
                            end
                            PH_PP: begin
                                r_phase <= PH_RDSR;
                                r_poll  <= '0;
                                r_state <= S_GAP;
                            end
                            default: begin
                                if (r_op == OP_STATUS || !spi_rdata[0]) begin
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_rdata <= w_status;
                                    r_state     <= S_RESP;
                                end else if (r_poll == POLL_LAST) begin
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_err   <= 1'b1;
                                    r_rsp_rdata <= w_status;
                                    r_state     <= S_RESP;
                                end else begin
                                    r_poll  <= r_poll + PW'(1);
                                    r_state <= S_GAP;
                                end
                            end
                        endcase
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_frame  <= frame_of(r_phase, r_addr, r_wdata);
                        r_spi_en <= 1'b1;
                        r_state  <= S_ISSUE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_err     = r_rsp_err;
    assign rsp_rdata   = r_rsp_rdata;
    assign spi_en      = r_spi_en;
    assign spi_command = r_frame.command;
    assign spi_address = r_frame.address;
    assign spi_wdata   = r_frame.wdata;

endmodule
